cdc_frame_parser: RTL and testbench



---
 rtl/cdc_frame_parser_if.sv | 35 +++
 rtl/cdc_frame_parser.sv | 188 ++++++++++++++++++
 tb/tb_cdc_frame_parser.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_frame_parser_if.sv
// cdc_frame_parser_if
//   Payload stream between the frame parser and the protocol engines.
//   valid/ready: a byte moves on every clock edge where pl_valid and
//   pl_ready are both high; pl_data and pl_last are meaningful only while
//   pl_valid is high, and pl_last marks the final payload byte of a frame.
//
//   Signals
//     pl_valid  producer -> consumer  payload byte available
//     pl_data   producer -> consumer  payload byte
//     pl_last   producer -> consumer  final payload byte of the frame
//     pl_ready  consumer -> producer  consumer accepts the byte
//
//   Modports
//     master : the parser (drives valid/data/last)
//     slave  : the downstream engine (drives ready)
interface cdc_frame_parser_if;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_last;
    logic       pl_ready;

    modport master (
        output pl_valid,
        output pl_data,
        output pl_last,
        input  pl_ready
    );

    modport slave (
        input  pl_valid,
        input  pl_data,
        input  pl_last,
        output pl_ready
    );
endinterface

// File: rtl/cdc_frame_parser.sv
// cdc_frame_parser
//   Command-frame parser on the read port of the USB-CDC receive FIFO
//   (first-word-fall-through). Finds 0xAA headers, extracts CMD and LEN,
//   streams LEN payload bytes with valid/ready and reports frame completion
//   or a classified error. Single clock domain (the FIFO read clock).
//
//   Frame: 0xAA, CMD, LEN, LEN payload bytes [, CKSUM]
//   CKSUM = (CMD + LEN + payload bytes) mod 256.
//
//   Build option
//     FRAME_CKSUM_EN  defined: trailing checksum byte is expected and
//                     checked (err_code 2 reachable). Undefined: frames
//                     end after the last payload byte.
//
//   Parameters
//     MAX_LEN      largest accepted LEN (1..255)
//     TIMEOUT_CYC  FIFO-starved cycles tolerated mid-frame (1..65535)
//
//   Ports
//     clk, rst_n           clock, synchronous active-low reset
//     fifo_rdata/rempty    FIFO head byte and empty flag
//     fifo_rinc            pop strobe (combinational)
//     cmd_valid            1-cycle pulse when a header is accepted
//     cmd_code, cmd_len    held until the next cmd_valid
//     pl                   payload stream (master modport, combinational)
//     frm_ok, frm_err      1-cycle completion / abort pulses
//     err_code             1=length, 2=checksum, 3=timeout; held
//     state_dbg            current FSM state encoding
module cdc_frame_parser #(
    parameter int MAX_LEN     = 64,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                fifo_rdata,
    input  logic                      fifo_rempty,
    output logic                      fifo_rinc,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_code,
    output logic [7:0]                cmd_len,
    cdc_frame_parser_if.master        pl,
    output logic                      frm_ok,
    output logic                      frm_err,
    output logic [1:0]                err_code,
    output logic [2:0]                state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CKSUM   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  cmd_reg;
    logic [7:0]  remaining;
    logic [15:0] tmo_cnt;
`ifdef FRAME_CKSUM_EN
    logic [7:0]  sum;
`else
    // LEN=0 frames report frm_ok one cycle after cmd_valid while the FSM is
    // already back in IDLE, so the next header is not delayed.
    logic        ok_pend;
`endif

    logic in_payload;
    logic pl_valid_w;

    assign in_payload  = (state == S_PAYLOAD);
    assign pl_valid_w  = in_payload && !fifo_rempty;
    assign pl.pl_valid = pl_valid_w;
    assign pl.pl_data  = fifo_rdata;
    assign pl.pl_last  = pl_valid_w && (remaining == 8'd1);
    // No pops while reset is held, so bytes queued across a reset survive.
    assign fifo_rinc   = rst_n && !fifo_rempty && (!in_payload || pl.pl_ready);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_reg   <= 8'd0;
            remaining <= 8'd0;
            tmo_cnt   <= 16'd0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'd0;
            cmd_len   <= 8'd0;
            frm_ok    <= 1'b0;
            frm_err   <= 1'b0;
            err_code  <= 2'd0;
`ifdef FRAME_CKSUM_EN
            sum       <= 8'd0;
`else
            ok_pend   <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            frm_err   <= 1'b0;
`ifdef FRAME_CKSUM_EN
            frm_ok    <= 1'b0;
`else
            frm_ok    <= ok_pend;
            ok_pend   <= 1'b0;
`endif

            if (fifo_rinc) begin
                case (state)
                    S_IDLE: begin
                        if (fifo_rdata == 8'hAA) state <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_reg <= fifo_rdata;
`ifdef FRAME_CKSUM_EN
                        sum     <= fifo_rdata;
`endif
                        state   <= S_LEN;
                    end
                    S_LEN: begin
                        if (fifo_rdata > 8'(MAX_LEN)) begin
                            frm_err  <= 1'b1;
                            err_code <= 2'd1;
                            state    <= S_IDLE;
                        end else begin
                            cmd_code  <= cmd_reg;
                            cmd_len   <= fifo_rdata;
                            cmd_valid <= 1'b1;
                            remaining <= fifo_rdata;
`ifdef FRAME_CKSUM_EN
                            sum       <= sum + fifo_rdata;
`endif
                            if (fifo_rdata == 8'd0) begin
`ifdef FRAME_CKSUM_EN
                                state   <= S_CKSUM;
`else
                                ok_pend <= 1'b1;
                                state   <= S_IDLE;
`endif
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        remaining <= remaining - 8'd1;
`ifdef FRAME_CKSUM_EN
                        sum       <= sum + fifo_rdata;
                        if (remaining == 8'd1) state <= S_CKSUM;
`else
                        if (remaining == 8'd1) begin
                            frm_ok <= 1'b1;
                            state  <= S_IDLE;
                        end
`endif
                    end
`ifdef FRAME_CKSUM_EN
                    S_CKSUM: begin
                        if (fifo_rdata == sum) begin
                            frm_ok <= 1'b1;
                        end else begin
                            frm_err  <= 1'b1;
                            err_code <= 2'd2;
                        end
                        state <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end

            // Starvation timer: counts only empty-FIFO cycles outside IDLE;
            // backpressure (FIFO non-empty, no pop) holds it.
            if (state == S_IDLE || fifo_rinc) begin
                tmo_cnt <= 16'd0;
            end else if (fifo_rempty) begin
                if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    frm_err  <= 1'b1;
                    err_code <= 2'd3;
                    state    <= S_IDLE;
                    tmo_cnt  <= 16'd0;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdc_frame_parser.sv
// tb_cdc_frame_parser
//   Directed bench for cdc_frame_parser with TIMEOUT_CYC=20, MAX_LEN=64.
//   A FIFO model feeds bytes; stimulus pushes the expected output events
//   into exp_q, and a negedge monitor pops and compares each event the DUT
//   presents. Builds with or without FRAME_CKSUM_EN.
module tb_cdc_frame_parser;

`ifdef FRAME_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  localparam logic [19:0] EV_OK = {4'd3, 16'd0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0] fifo_rdata;
  logic       fifo_rempty;
  logic       fifo_rinc;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_len;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic [2:0] state_dbg;

  cdc_frame_parser_if pl_if ();

  cdc_frame_parser #(
    .MAX_LEN(64),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_len(cmd_len),
    .pl(pl_if),
    .frm_ok(frm_ok),
    .frm_err(frm_err),
    .err_code(err_code),
    .state_dbg(state_dbg)
  );

  // ---------------- FIFO model (FWFT) ----------------
  logic [7:0]  fifo_mem [0:4095];
  logic [11:0] wr_ptr;
  logic [11:0] rd_ptr;

  assign fifo_rempty = (rd_ptr == wr_ptr);
  assign fifo_rdata  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_rinc) rd_ptr <= rd_ptr + 12'd1;
  end

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check_evt(input logic [19:0] got, input string name);
    logic [19:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got event %h, expected no event", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s: got event %h, expected %h", name, got, exp);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // monitor: one pass per cycle, event order CMD, PL, OK, ERR
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cmd_valid) check_evt({4'd1, cmd_code, cmd_len}, "cmd");
      if (pl_if.pl_valid && pl_if.pl_ready)
        check_evt({4'd2, 7'd0, pl_if.pl_last, pl_if.pl_data}, "payload");
      if (frm_ok) check_evt(EV_OK, "frm_ok");
      if (frm_err) check_evt({4'd4, 8'd0, 6'd0, err_code}, "frm_err");
      if (fifo_rinc) begin
        check_val("rinc_while_empty", {31'd0, fifo_rempty}, 32'd0);
        if (pl_if.pl_valid)
          check_val("rinc_without_ready", {31'd0, pl_if.pl_ready}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 12'd1;
  endtask

  // payload byte i = seed + i; checksum = cmd + len + payload (mod 256)
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] seed, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    push_byte(8'hAA);
    push_byte(cmd);
    push_byte(len);
    sum = cmd + len;
    exp_q.push_back({4'd1, cmd, len});
    for (int i = 0; i < int'(len); i++) begin
      b = seed + 8'(i);
      sum = sum + b;
      push_byte(b);
      exp_q.push_back({4'd2, 7'd0, (i == int'(len) - 1), b});
    end
    if (CK == 1) begin
      push_byte(bad ? (sum ^ 8'h0E) : sum);
      exp_q.push_back(bad ? {4'd4, 8'd0, 8'd2} : EV_OK);
    end else begin
      exp_q.push_back(EV_OK);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !fifo_rempty) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check_val({name, "_drain"}, exp_q.size(), 32'd0);
    #2;
  endtask

  task automatic check_idle_outputs(input string name);
    check_val({name, "_rinc"}, {31'd0, fifo_rinc}, 32'd0);
    check_val({name, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check_val({name, "_pl_valid"}, {31'd0, pl_if.pl_valid}, 32'd0);
    check_val({name, "_pl_last"}, {31'd0, pl_if.pl_last}, 32'd0);
    check_val({name, "_frm_ok"}, {31'd0, frm_ok}, 32'd0);
    check_val({name, "_frm_err"}, {31'd0, frm_err}, 32'd0);
    check_val({name, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
    check_val({name, "_cmd_len"}, {24'd0, cmd_len}, 32'd0);
    check_val({name, "_err_code"}, {30'd0, err_code}, 32'd0);
    check_val({name, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    pl_if.pl_ready = 1'b1;
    wr_ptr = 12'd0;
    rd_ptr = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    drive_point();
    rst_n = 1'b1;
    drive_point();

    // basic frame with timing: cmd_valid after LEN pop (P3), frm_ok after
    // the last pop (P6, or P7 with checksum)
    send_frame(8'h10, 8'd3, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t1_cmd_valid_cycle", {31'd0, cmd_valid}, 32'd1);
    repeat (2 + CK) @(posedge clk);
    @(negedge clk);
    check_val("t1_frm_ok_early", {31'd0, frm_ok}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("t1_frm_ok_cycle", {31'd0, frm_ok}, 32'd1);
    wait_drain("t1");
    check_val("t1_cmd_code_held", {24'd0, cmd_code}, 32'h10);
    check_val("t1_cmd_len_held", {24'd0, cmd_len}, 32'd3);

    // bad checksum
    if (CK == 1) begin
      send_frame(8'h10, 8'd3, 8'h01, 1'b1);
      wait_drain("t2");
      check_val("t2_err_code", {30'd0, err_code}, 32'd2);
    end

    // garbage then over-length header, then a good frame
    push_byte(8'h55);
    push_byte(8'h00);
    push_byte(8'hAA);
    push_byte(8'h20);
    push_byte(8'h41);
    exp_q.push_back({4'd4, 8'd0, 8'd1});
    send_frame(8'h21, 8'd2, 8'h40, 1'b0);
    wait_drain("t3");

    // LEN=0: frm_ok the cycle after cmd_valid
    send_frame(8'h33, 8'd0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t4_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check_val("t4_frm_ok_early", {31'd0, frm_ok}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("t4_frm_ok", {31'd0, frm_ok}, 32'd1);
    wait_drain("t4");

    // LEN=MAX_LEN accepted; 0xAA as CMD and payload is data; back-to-back
    send_frame(8'hAA, 8'd64, 8'hAA, 1'b0);
    send_frame(8'h05, 8'd1, 8'hAA, 1'b0);
    send_frame(8'h06, 8'd0, 8'h00, 1'b0);
    wait_drain("t5");

    // timeout: AA 01 02 then starvation; frm_err 20 cycles after LEN pop
    push_byte(8'hAA);
    push_byte(8'h01);
    push_byte(8'h02);
    exp_q.push_back({4'd1, 8'h01, 8'h02});
    exp_q.push_back({4'd4, 8'd0, 8'd3});
    repeat (22) @(posedge clk);
    @(negedge clk);
    check_val("t6_err_early", {31'd0, frm_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("t6_err_cycle", {31'd0, frm_err}, 32'd1);
    check_val("t6_err_code", {30'd0, err_code}, 32'd3);
    wait_drain("t6");

    // backpressure: FIFO full, ready low 40 cycles then toggling
    pl_if.pl_ready = 1'b0;
    send_frame(8'h44, 8'd8, 8'hF0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive_point();
      pl_if.pl_ready = (i < 40) ? 1'b0 : 1'(i % 2);
    end
    pl_if.pl_ready = 1'b1;
    wait_drain("t7");

    // reset mid-payload
    pl_if.pl_ready = 1'b0;
    send_frame(8'h30, 8'd5, 8'h11, 1'b0);
    repeat (6) @(posedge clk);
    check_val("t8_in_payload", {29'd0, state_dbg}, 32'd3);
    // frame is abandoned: drop its remaining expectations (payload, end)
    while (exp_q.size() != 0) void'(exp_q.pop_back());
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t8_reset");
    drive_point();
    rst_n = 1'b1;
    pl_if.pl_ready = 1'b1;
    wait_drain("t8_flush");
    send_frame(8'h31, 8'd4, 8'h60, 1'b0);
    wait_drain("t8_after");

    check_val("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
